pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_pkg.sv | 13 +
 rtl/pwm_duty_div.sv | 72 +++++++
 rtl/pwm_capture.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM encodings and duty scale.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam int DUTY_W     = 10;
   localparam int DUTY_SCALE = 1024;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider: quotient = floor(dividend * DUTY_SCALE / divisor), one bit per clock.
// Assumes dividend < divisor. The first bit is resolved on the start edge, so done fires DUTY_W cycles after start.
module pwm_duty_div
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  dividend,
   input  logic [CNT_W-1:0]  divisor,
   output logic [DUTY_W-1:0] quotient,
   output logic              done
);

   localparam int STEP_W = $clog2(DUTY_W + 1);

   logic              busy_reg;
   logic [STEP_W-1:0] step_reg;
   logic [CNT_W-1:0]  rem_reg;
   logic [CNT_W-1:0]  div_reg;
   logic [DUTY_W-1:0] q_reg;

   logic [CNT_W:0]    rem_sh;
   logic [CNT_W:0]    diff;
   logic [CNT_W-1:0]  step_div;
   logic              q_bit;
   logic [CNT_W-1:0]  rem_next;
   logic [DUTY_W-1:0] q_next;

   // A start always overrides an in-flight division, so aborted results never reach quotient.
   always_comb begin
      step_div = start ? divisor : div_reg;
      rem_sh   = start ? {dividend, 1'b0} : {rem_reg, 1'b0};
      diff     = rem_sh - {1'b0, step_div};
      q_bit    = (rem_sh >= {1'b0, step_div});
      rem_next = q_bit ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
      q_next   = start ? {{(DUTY_W-1){1'b0}}, q_bit} : {q_reg[DUTY_W-2:0], q_bit};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg <= 1'b0;
         step_reg <= '0;
         rem_reg  <= '0;
         div_reg  <= '0;
         q_reg    <= '0;
         quotient <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy_reg <= 1'b1;
            step_reg <= STEP_W'(1);
            rem_reg  <= rem_next;
            div_reg  <= divisor;
            q_reg    <= q_next;
         end else if (busy_reg) begin
            rem_reg  <= rem_next;
            q_reg    <= q_next;
            step_reg <= step_reg + STEP_W'(1);
            if (step_reg == STEP_W'(DUTY_W - 1)) begin
               busy_reg <= 1'b0;
               quotient <= q_next;
               done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, with stuck-input detection.
// Define PWM_CAPTURE_DUTY_EN to add the duty-cycle divider; otherwise duty/duty_valid read 0.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W       = 20,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  high_time,
   output logic [CNT_W-1:0]  period,
   output logic              meas_valid,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_valid,
   output logic              stuck,
   output logic              stuck_level
);

   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_HOLD = CNT_W'(TIMEOUT_CYC);

   function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   logic             sync1_reg, sync2_reg, hist_reg;
   logic             rise, fall, any_edge, timeout;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] hcnt_reg, hcnt_next;
   logic [CNT_W-1:0] pcnt_reg, pcnt_next;
   logic [CNT_W-1:0] idle_cnt_reg;
   logic             latch;
   logic [CNT_W-1:0] high_time_reg, period_reg;
   logic             meas_valid_reg, stuck_reg, stuck_level_reg;

   assign rise     = sync2_reg & ~hist_reg;
   assign fall     = ~sync2_reg & hist_reg;
   assign any_edge = rise | fall;
   // An edge in the same cycle always wins over the timeout.
   assign timeout  = ~any_edge && (idle_cnt_reg == TIMEOUT_LAST);

   always_comb begin
      state_next = state_reg;
      hcnt_next  = hcnt_reg;
      pcnt_next  = pcnt_reg;
      latch      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (rise) begin
               state_next = ST_HIGH;
               hcnt_next  = CNT_W'(1);
               pcnt_next  = CNT_W'(1);
            end
         end
         ST_HIGH: begin
            pcnt_next = inc_sat(pcnt_reg);
            if (fall) state_next = ST_LOW;
            else      hcnt_next  = inc_sat(hcnt_reg);
         end
         ST_LOW: begin
            if (rise) begin
               latch      = 1'b1;
               state_next = ST_HIGH;
               hcnt_next  = CNT_W'(1);
               pcnt_next  = CNT_W'(1);
            end else begin
               pcnt_next = inc_sat(pcnt_reg);
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (timeout) begin
         state_next = ST_IDLE;
         hcnt_next  = '0;
         pcnt_next  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg       <= 1'b0;
         sync2_reg       <= 1'b0;
         hist_reg        <= 1'b0;
         state_reg       <= ST_IDLE;
         hcnt_reg        <= '0;
         pcnt_reg        <= '0;
         idle_cnt_reg    <= '0;
         high_time_reg   <= '0;
         period_reg      <= '0;
         meas_valid_reg  <= 1'b0;
         stuck_reg       <= 1'b0;
         stuck_level_reg <= 1'b0;
      end else begin
         sync1_reg      <= pwm_in;
         sync2_reg      <= sync1_reg;
         hist_reg       <= sync2_reg;
         state_reg      <= state_next;
         hcnt_reg       <= hcnt_next;
         pcnt_reg       <= pcnt_next;
         meas_valid_reg <= latch;
         if (latch) begin
            high_time_reg <= hcnt_reg;
            period_reg    <= pcnt_reg;
         end
         // Edge-free counter parks at TIMEOUT_CYC so the timeout fires only once.
         if (any_edge)
            idle_cnt_reg <= '0;
         else if (idle_cnt_reg != TIMEOUT_HOLD)
            idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
         if (any_edge) begin
            stuck_reg <= 1'b0;
         end else if (timeout) begin
            stuck_reg       <= 1'b1;
            stuck_level_reg <= sync2_reg;
         end
      end
   end

   assign high_time   = high_time_reg;
   assign period      = period_reg;
   assign meas_valid  = meas_valid_reg;
   assign stuck       = stuck_reg;
   assign stuck_level = stuck_level_reg;

`ifdef PWM_CAPTURE_DUTY_EN
   logic div_start;
   assign div_start = meas_valid_reg && (period_reg != '0);

   pwm_duty_div #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (high_time_reg),
      .divisor  (period_reg),
      .quotient (duty),
      .done     (duty_valid)
   );
`else
   assign duty       = '0;
   assign duty_valid = 1'b0;
`endif

endmodule
